// File: rtl/difftest_commit_monitor_if.sv
// rtl/difftest_commit_monitor_if.sv - writeback-in / commit-out bus of the difftest commit monitor
//
// Groups the per-lane pipeline writeback signals (wb_*) and the registered
// commit signals (cmt_*) that feed the difftest DPI modules.
//   master : pipeline / stimulus side, drives wb_*, observes cmt_*
//   slave  : monitor side, observes wb_*, drives cmt_*
// Lane i occupies [i*W +: W] of every flat vector; lane 0 is the oldest.
interface difftest_commit_monitor_if #(
    parameter int NR_COMMIT = 2,
    parameter int XLEN      = 64
);
    logic [NR_COMMIT*XLEN-1:0] wb_pc;
    logic [NR_COMMIT*32-1:0]   wb_inst;
    logic [NR_COMMIT-1:0]      wb_rf_we;
    logic [NR_COMMIT*5-1:0]    wb_rf_wnum;
    logic [NR_COMMIT*XLEN-1:0] wb_rf_wdata;

    logic [NR_COMMIT-1:0]      cmt_valid;
    logic [NR_COMMIT*XLEN-1:0] cmt_pc;
    logic [NR_COMMIT*32-1:0]   cmt_inst;
    logic [NR_COMMIT-1:0]      cmt_wen;
    logic [NR_COMMIT*8-1:0]    cmt_wdest;
    logic [NR_COMMIT*XLEN-1:0] cmt_wdata;

    modport master (
        output wb_pc, wb_inst, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
        input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata
    );

    modport slave (
        input  wb_pc, wb_inst, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
        output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata
    );
endinterface

// File: rtl/difftest_commit_monitor.sv
// rtl/difftest_commit_monitor.sv - multi-lane difftest commit capture with trap detect, counters and watchdog
//
// Registers up to NR_COMMIT writebacks per cycle (lane 0 oldest), detects the
// trap instruction (opcode 7'h6b), counts cycles and retired instructions and
// halts after WDOG_CYCLES consecutive cycles without a valid lane.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    wb_* inputs from the pipeline, cmt_* registered outputs
//   a0_value       current x10, low byte becomes the trap code
//   trap           sticky halt flag
//   trap_code      a0[7:0] at trap instruction, 8'hFF on watchdog expiry
//   trap_pc        PC of the trapping lane, or last committed PC on watchdog
//   cycle_cnt      RUN cycles since reset (frozen once halted)
//   instr_cnt      retired instructions since reset (frozen once halted)
//   regs_in/regs_diff  only with DIFFTEST_REGS_SNAPSHOT_EN: register file
//                  snapshot captured alongside cmt_*
//
// Optional feature macro: DIFFTEST_REGS_SNAPSHOT_EN
module difftest_commit_monitor #(
    parameter int              NR_COMMIT   = 2,
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] PC_START    = XLEN'(64'h8000_0000),
    parameter int              WDOG_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    difftest_commit_monitor_if.slave  bus,
    input  logic [XLEN-1:0]           a0_value,
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
    input  logic [32*XLEN-1:0]        regs_in,
    output logic [32*XLEN-1:0]        regs_diff,
`endif
    output logic                      trap,
    output logic [7:0]                trap_code,
    output logic [XLEN-1:0]           trap_pc,
    output logic [63:0]               cycle_cnt,
    output logic [63:0]               instr_cnt
);

    localparam int              WDOG_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);
    localparam logic [6:0]      TRAP_OP  = 7'h6b;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [NR_COMMIT-1:0]      cmt_valid_q, cmt_valid_d;
    logic [NR_COMMIT*XLEN-1:0] cmt_pc_q,    cmt_pc_d;
    logic [NR_COMMIT*32-1:0]   cmt_inst_q,  cmt_inst_d;
    logic [NR_COMMIT-1:0]      cmt_wen_q,   cmt_wen_d;
    logic [NR_COMMIT*8-1:0]    cmt_wdest_q, cmt_wdest_d;
    logic [NR_COMMIT*XLEN-1:0] cmt_wdata_q, cmt_wdata_d;
    logic [7:0]                trap_code_q, trap_code_d;
    logic [XLEN-1:0]           trap_pc_q,   trap_pc_d;
    logic [63:0]               cycle_cnt_q, cycle_cnt_d;
    logic [63:0]               instr_cnt_q, instr_cnt_d;
    logic [WDOG_W-1:0]         wdog_cnt_q,  wdog_cnt_d;
    logic [XLEN-1:0]           last_pc_q,   last_pc_d;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
    logic [32*XLEN-1:0]        regs_diff_q, regs_diff_d;
`endif

    // Lane decode results
    logic [NR_COMMIT-1:0] commit;
    logic                 any_valid;
    logic                 trap_hit;
    logic [XLEN-1:0]      trap_pc_sel;
    logic [XLEN-1:0]      commit_pc;
    logic [63:0]          commit_cnt;
    logic [WDOG_W-1:0]    wdog_inc;
    logic                 wdog_expire;

    // Lanes are scanned oldest first; once a trap lane is seen every younger
    // lane is suppressed. commit_pc ends up as the youngest committed PC.
    always_comb begin
        commit      = '0;
        any_valid   = 1'b0;
        trap_hit    = 1'b0;
        trap_pc_sel = '0;
        commit_pc   = last_pc_q;
        commit_cnt  = '0;
        for (int i = 0; i < NR_COMMIT; i++) begin
            if ((bus.wb_pc[i*XLEN +: XLEN] != PC_START) || (bus.wb_inst[i*32 +: 32] != 32'h0)) begin
                any_valid = 1'b1;
                if (!trap_hit) begin
                    commit[i]  = 1'b1;
                    commit_cnt = commit_cnt + 64'd1;
                    commit_pc  = bus.wb_pc[i*XLEN +: XLEN];
                    if (bus.wb_inst[i*32 +: 7] == TRAP_OP) begin
                        trap_hit    = 1'b1;
                        trap_pc_sel = bus.wb_pc[i*XLEN +: XLEN];
                    end
                end
            end
        end
        wdog_inc    = (wdog_cnt_q == WDOG_MAX) ? WDOG_MAX : wdog_cnt_q + 1'b1;
        // A trap lane is always a valid lane, so expiry and trap can never
        // coincide; trap_hit still takes priority below for clarity.
        wdog_expire = !any_valid && (wdog_inc == WDOG_MAX);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_RUN) && (trap_hit || wdog_expire)) begin
            state_d = ST_HALT;
        end
    end

    // FSM: outputs and datapath next values
    always_comb begin
        cmt_valid_d = '0;
        cmt_pc_d    = cmt_pc_q;
        cmt_inst_d  = cmt_inst_q;
        cmt_wen_d   = cmt_wen_q;
        cmt_wdest_d = cmt_wdest_q;
        cmt_wdata_d = cmt_wdata_q;
        trap_code_d = trap_code_q;
        trap_pc_d   = trap_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        wdog_cnt_d  = wdog_cnt_q;
        last_pc_d   = last_pc_q;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        regs_diff_d = regs_diff_q;
`endif
        if (state_q == ST_RUN) begin
            cmt_valid_d = commit;
            cmt_pc_d    = bus.wb_pc;
            cmt_inst_d  = bus.wb_inst;
            cmt_wdata_d = bus.wb_rf_wdata;
            for (int i = 0; i < NR_COMMIT; i++) begin
                cmt_wen_d[i]         = bus.wb_rf_we[i] && (bus.wb_rf_wnum[i*5 +: 5] != 5'd0);
                cmt_wdest_d[i*8 +: 8] = {3'b000, bus.wb_rf_wnum[i*5 +: 5]};
            end
            cycle_cnt_d = cycle_cnt_q + 64'd1;
            instr_cnt_d = instr_cnt_q + commit_cnt;
            wdog_cnt_d  = any_valid ? '0 : wdog_inc;
            last_pc_d   = commit_pc;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
            regs_diff_d = regs_in;
`endif
            if (trap_hit) begin
                trap_code_d = a0_value[7:0];
                trap_pc_d   = trap_pc_sel;
            end else if (wdog_expire) begin
                trap_code_d = 8'hFF;
                trap_pc_d   = last_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_valid_q <= '0;
            cmt_pc_q    <= '0;
            cmt_inst_q  <= '0;
            cmt_wen_q   <= '0;
            cmt_wdest_q <= '0;
            cmt_wdata_q <= '0;
            trap_code_q <= '0;
            trap_pc_q   <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            wdog_cnt_q  <= '0;
            last_pc_q   <= '0;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
            regs_diff_q <= '0;
`endif
        end else begin
            cmt_valid_q <= cmt_valid_d;
            cmt_pc_q    <= cmt_pc_d;
            cmt_inst_q  <= cmt_inst_d;
            cmt_wen_q   <= cmt_wen_d;
            cmt_wdest_q <= cmt_wdest_d;
            cmt_wdata_q <= cmt_wdata_d;
            trap_code_q <= trap_code_d;
            trap_pc_q   <= trap_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            last_pc_q   <= last_pc_d;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
            regs_diff_q <= regs_diff_d;
`endif
        end
    end

    assign trap          = (state_q == ST_HALT);
    assign bus.cmt_valid = cmt_valid_q;
    assign bus.cmt_pc    = cmt_pc_q;
    assign bus.cmt_inst  = cmt_inst_q;
    assign bus.cmt_wen   = cmt_wen_q;
    assign bus.cmt_wdest = cmt_wdest_q;
    assign bus.cmt_wdata = cmt_wdata_q;
    assign trap_code     = trap_code_q;
    assign trap_pc       = trap_pc_q;
    assign cycle_cnt     = cycle_cnt_q;
    assign instr_cnt     = instr_cnt_q;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
    assign regs_diff     = regs_diff_q;
`endif

endmodule

// File: tb/tb_difftest_commit_monitor.sv
// tb/tb_difftest_commit_monitor.sv - self-checking bench for difftest_commit_monitor
module tb_difftest_commit_monitor;
    localparam int          NR  = 2;
    localparam int          XL  = 64;
    localparam int          WD  = 8;
    localparam logic [63:0] PCS = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a0_value;
    logic        trap;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
    logic [32*XL-1:0] regs_in;
    logic [32*XL-1:0] regs_diff;
    logic [32*XL-1:0] e_regs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    difftest_commit_monitor_if #(.NR_COMMIT(NR), .XLEN(XL)) bus ();

    difftest_commit_monitor #(
        .NR_COMMIT  (NR),
        .XLEN       (XL),
        .PC_START   (PCS),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .a0_value (a0_value),
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        .regs_in  (regs_in),
        .regs_diff(regs_diff),
`endif
        .trap     (trap),
        .trap_code(trap_code),
        .trap_pc  (trap_pc),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    // Reference model state
    logic [NR-1:0] e_valid;
    logic [63:0]   e_pc    [NR];
    logic [31:0]   e_inst  [NR];
    logic          e_wen   [NR];
    logic [7:0]    e_wdest [NR];
    logic [63:0]   e_wdata [NR];
    logic          e_trap;
    logic [7:0]    e_code;
    logic [63:0]   e_tpc;
    logic [63:0]   e_cycle;
    logic [63:0]   e_instr;
    logic [63:0]   m_last_pc;
    int            m_idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid   = '0;
        e_trap    = 1'b0;
        e_code    = '0;
        e_tpc     = '0;
        e_cycle   = '0;
        e_instr   = '0;
        m_last_pc = '0;
        m_idle    = 0;
        for (int i = 0; i < NR; i++) begin
            e_pc[i] = '0; e_inst[i] = '0; e_wen[i] = 1'b0; e_wdest[i] = '0; e_wdata[i] = '0;
        end
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        e_regs = '0;
`endif
    endtask

    // One clock edge of the specified behaviour, evaluated from the stimulus.
    task automatic model_edge();
        int  trap_lane;
        int  retired;
        bit  seen_valid;
        logic [63:0] pc;
        logic [31:0] inst;
        if (e_trap) begin
            e_valid = '0;
            return;
        end
        trap_lane  = -1;
        retired    = 0;
        seen_valid = 0;
        for (int i = 0; i < NR; i++) begin
            pc   = bus.wb_pc[i*XL +: XL];
            inst = bus.wb_inst[i*32 +: 32];
            e_pc[i]    = pc;
            e_inst[i]  = inst;
            e_wen[i]   = bus.wb_rf_we[i] && (bus.wb_rf_wnum[i*5 +: 5] != 0);
            e_wdest[i] = {3'b000, bus.wb_rf_wnum[i*5 +: 5]};
            e_wdata[i] = bus.wb_rf_wdata[i*XL +: XL];
            e_valid[i] = 1'b0;
            if (pc != PCS || inst != 0) begin
                seen_valid = 1;
                if (trap_lane < 0) begin
                    e_valid[i] = 1'b1;
                    retired++;
                    m_last_pc = pc;
                    if (inst[6:0] == 7'h6b) trap_lane = i;
                end
            end
        end
        e_cycle = e_cycle + 1;
        e_instr = e_instr + 64'(retired);
        m_idle  = seen_valid ? 0 : m_idle + 1;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        e_regs = regs_in;
`endif
        if (trap_lane >= 0) begin
            e_trap = 1'b1;
            e_code = a0_value[7:0];
            e_tpc  = e_pc[trap_lane];
        end else if (m_idle >= WD) begin
            e_trap = 1'b1;
            e_code = 8'hFF;
            e_tpc  = m_last_pc;
        end
    endtask

    task automatic compare_all();
        check("cmt_valid", 64'(bus.cmt_valid), 64'(e_valid));
        for (int i = 0; i < NR; i++) begin
            if (e_valid[i]) begin
                check($sformatf("pc%0d", i), bus.cmt_pc[i*XL +: XL], e_pc[i]);
                check($sformatf("inst%0d", i), 64'(bus.cmt_inst[i*32 +: 32]), 64'(e_inst[i]));
                check($sformatf("wen%0d", i), 64'(bus.cmt_wen[i]), 64'(e_wen[i]));
                check($sformatf("wdest%0d", i), 64'(bus.cmt_wdest[i*8 +: 8]), 64'(e_wdest[i]));
                check($sformatf("wdata%0d", i), bus.cmt_wdata[i*XL +: XL], e_wdata[i]);
            end
        end
        check("trap", 64'(trap), 64'(e_trap));
        check("trap_code", 64'(trap_code), 64'(e_code));
        check("trap_pc", trap_pc, e_tpc);
        check("cycle_cnt", cycle_cnt, e_cycle);
        check("instr_cnt", instr_cnt, e_instr);
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        check("regs_x10", regs_diff[10*XL +: XL], e_regs[10*XL +: XL]);
        check("regs_x1", regs_diff[1*XL +: XL], e_regs[1*XL +: XL]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] inst,
                            input logic we, input logic [4:0] wnum, input logic [63:0] wd);
        bus.wb_pc[i*XL +: XL]       = pc;
        bus.wb_inst[i*32 +: 32]     = inst;
        bus.wb_rf_we[i]             = we;
        bus.wb_rf_wnum[i*5 +: 5]    = wnum;
        bus.wb_rf_wdata[i*XL +: XL] = wd;
    endtask

    task automatic all_bubble();
        for (int i = 0; i < NR; i++) set_lane(i, PCS, 32'h0, 1'b0, 5'd0, 64'h0);
    endtask

    task automatic drive_random(input int trap_pct, input int bub_pct);
        int          r;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  wnum;
        for (int i = 0; i < NR; i++) begin
            r    = $urandom_range(0, 99);
            pc   = {32'h0, $urandom} & ~64'h3;
            inst = $urandom;
            if (inst[6:0] == 7'h6b) inst[6:0] = 7'h33;
            if ($urandom_range(0, 99) < trap_pct) inst[6:0] = 7'h6b;
            if (inst == 0) inst = 32'h13;
            wnum = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if (r < bub_pct)       set_lane(i, PCS, 32'h0, 1'b0, 5'd0, 64'h0);
            else if (r < bub_pct + 8) set_lane(i, PCS, inst, 1'($urandom), wnum, {$urandom, $urandom});
            else if (r < bub_pct + 12) set_lane(i, pc, 32'h0, 1'($urandom), wnum, {$urandom, $urandom});
            else                   set_lane(i, pc, inst, 1'($urandom), wnum, {$urandom, $urandom});
        end
        a0_value = {$urandom, $urandom};
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        for (int j = 0; j < 32; j++) regs_in[j*XL +: XL] = {$urandom, $urandom};
`endif
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_trap", 64'(trap), 64'h0);
        check("rst_cycle", cycle_cnt, 64'h0);
        all_bubble();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        all_bubble();
        a0_value = '0;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
        regs_in = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_valid", 64'(bus.cmt_valid), 64'h0);
        check("rst_instr", instr_cnt, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three bubble cycles after release
        repeat (3) step();
        check("t1_cycle", cycle_cnt, 64'd3);
        check("t1_instr", instr_cnt, 64'd0);

        // Dual commit, lane 1 writes x0
        set_lane(0, 64'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 64'hAA);
        set_lane(1, 64'h8000_0008, 32'h0000_0013, 1'b1, 5'd0, 64'h55);
        step();
        check("t2_valid", 64'(bus.cmt_valid), 64'h3);
        check("t2_wen", 64'(bus.cmt_wen), 64'h1);
        check("t2_wdest0", 64'(bus.cmt_wdest[7:0]), 64'd5);
        check("t2_wdata0", bus.cmt_wdata[63:0], 64'hAA);
        check("t2_instr", instr_cnt, 64'd2);

        // Random commits without traps
        for (int n = 0; n < 150 && !e_trap; n++) begin
            drive_random(0, 25);
            step();
        end

        // Trap in lane 0, lane 1 valid and suppressed
        if (!e_trap) begin
            set_lane(0, 64'h8000_0100, 32'h0000_006b, 1'b0, 5'd0, 64'h0);
            set_lane(1, 64'h8000_0104, 32'h0000_0013, 1'b1, 5'd7, 64'h77);
            a0_value = 64'h1234;
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
            regs_in[10*XL +: XL] = 64'd7;
`endif
            step();
            check("t3_valid", 64'(bus.cmt_valid), 64'h1);
            check("t3_trap", 64'(trap), 64'h1);
            check("t3_code", 64'(trap_code), 64'h34);
            check("t3_pc", trap_pc, 64'h8000_0100);
`ifdef DIFFTEST_REGS_SNAPSHOT_EN
            check("t6_x10", regs_diff[10*XL +: XL], 64'd7);
`endif
        end
        repeat (4) begin
            drive_random(10, 25);
            step();
        end
        check("t3_halt_valid", 64'(bus.cmt_valid), 64'h0);

        // Asynchronous reset while halted, capture resumes
        do_reset();
        set_lane(0, 64'h8000_0200, 32'h0000_0013, 1'b1, 5'd3, 64'h33);
        step();
        check("t5_valid", 64'(bus.cmt_valid), 64'h1);
        check("t5_cycle", cycle_cnt, 64'd1);
        check("t5_instr", instr_cnt, 64'd1);

        // Random rounds with traps and watchdog possible
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int n = 0; n < 200 && !e_trap; n++) begin
                drive_random(3, 40);
                step();
            end
            repeat (3) begin
                drive_random(3, 40);
                step();
            end
        end

        // Watchdog expiry after a commit at 0x80000010
        do_reset();
        set_lane(0, 64'h8000_0010, 32'h0000_0013, 1'b0, 5'd0, 64'h0);
        set_lane(1, PCS, 32'h0, 1'b0, 5'd0, 64'h0);
        step();
        all_bubble();
        a0_value = 64'h42;
        repeat (WD - 1) step();
        check("t4_not_yet", 64'(trap), 64'h0);
        step();
        check("t4_trap", 64'(trap), 64'h1);
        check("t4_code", 64'(trap_code), 64'hFF);
        check("t4_pc", trap_pc, 64'h8000_0010);
        check("t4_cycle", cycle_cnt, 64'(WD + 1));
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
